maze_rom_arbiter: RTL
=====================

MAZE_ROM_ARBITER -- requirements
Module: maze_rom_arbiter

Interface
REQ-001 Parameter WALL_COLOUR, 16'hFFFF, RGB565 value that marks a wall pixel.
REQ-002 Parameter PLAYER_COLOUR, 16'hF800, RGB565 value drawn for the player sprite.
REQ-003 Parameter START_X, 5, player box left column after reset.
REQ-004 Parameter START_Y, 5, player box top row after reset.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pixel_index  in  13  OLED scan address, y*96+x.
REQ-008 pixel_data  out  16  colour for the sampled pixel_index, with the sprite overlaid.
REQ-009 rom_index  out  13  registered address to the shared maze ROM.
REQ-010 rom_data  in  16  maze ROM output, valid 1 cycle after rom_index changes.
REQ-011 move_req  in  1  single-cycle move request.
REQ-012 move_dir  in  2  move direction: 0 up, 1 down, 2 left, 3 right.
REQ-013 move_done  out  1  one-cycle pulse when a move request completes.
REQ-014 move_ok  out  1  result of the last move; valid from move_done onward.
REQ-015 player_x  out  7  left column of the 3x3 player box.
REQ-016 player_y  out  6  top row of the 3x3 player box.
REQ-017 at_goal  out  1  high while player_y+2 >= 61.

Function
REQ-018 A slot bit toggles every cycle, starting at 0 after reset: slot 0 serves the display and slot 1 serves the checker.
REQ-019 At each slot-0 edge, rom_index <= pixel_index and the sampled index is stored; 2 cycles later, pixel_data is updated and then held until the next update.
REQ-020 pixel_data = PLAYER_COLOUR when the stored index lies inside the box [player_x..+2] x [player_y..+2]; otherwise pixel_data = rom_data.
REQ-021 FSM states: IDLE, BOUNDS, PROBE, DONE.
REQ-022 move_req is accepted only in IDLE; in any other state it is ignored, with no queuing.
REQ-023 On acceptance, the candidate position (cand_x, cand_y) = player position stepped 1 pixel in move_dir, and the FSM enters BOUNDS.
REQ-024 BOUNDS: if the candidate box leaves the 96x64 area (underflow or x+2>95 or y+2>63), go to DONE with a fail result and no probes; otherwise go to PROBE.
REQ-025 PROBE issues 9 addresses, (cand_y+r)*96 + cand_x+c in row-major order, one per slot-1 edge; each rom_data is sampled 2 cycles after issue.
REQ-026 All 9 probes always run (no early abort); any sample equal to WALL_COLOUR marks the move as failed.
REQ-027 DONE lasts 1 cycle: move_done=1, move_ok=pass, player position updated on pass; the FSM then returns to IDLE.
REQ-028 move_done occurs at most 21 cycles after acceptance; a bounds fail gives move_done exactly 2 cycles after acceptance.
REQ-029 Display service is never delayed by the checker; display latency is fixed whatever the FSM state.
REQ-030 Position arithmetic uses 8-bit signed intermediates; no wrap-around is permitted.

Reset
REQ-031 Reset gives: slot=0, state IDLE, rom_index=0, pixel_data=0, move_done=0, move_ok=0, player_x=START_X, player_y=START_Y.
REQ-032 Reset during BOUNDS or PROBE abandons the move: no move_done pulse and no position update.

Structure
REQ-033 Package maze_pkg holds MAZE_W=96, MAZE_H=64, the direction encodings, the FSM state enum, and the default colours.
REQ-034 One sub-module, maze_sprite_hit, is combinational and tests whether an index lies inside the 3x3 box.

Verification
REQ-035 Reset, then pixel_index=5*96+5 -> pixel_data=16'hF800; pixel_index=0 -> pixel_data=16'hFFFF, each 2 cycles after its slot-0 sample.
REQ-036 From (5,5), move_dir=3 -> move_done within 21 cycles, move_ok=1, player_x=6.
REQ-037 From (5,5), three lefts -> (4,5) ok, (3,5) ok, third move fails (column 2 is wall) and player_x stays 3.
REQ-038 A move_req pulsed while in PROBE is ignored: exactly one move_done, and the position moves one step only.
REQ-039 Reset asserted at probe 4 -> no move_done, player back to (5,5), IDLE accepts the next request.
REQ-040 Throughout all moves, the pixel_data stream matches a reference model cycle-exactly, with no display stalls.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze ROM arbiter: geometry, encodings, colours
// and small address helpers.
package maze_pkg;

  localparam int unsigned MAZE_W = 96;
  localparam int unsigned MAZE_H = 64;
  localparam int unsigned IDX_W  = 13;

  localparam logic [15:0] DEF_WALL_COLOUR   = 16'hFFFF;
  localparam logic [15:0] DEF_PLAYER_COLOUR = 16'hF800;

  // Largest legal coordinate of the box edge, as signed 8-bit values
  localparam logic signed [7:0] EDGE_X_MAX = 8'(MAZE_W - 1);
  localparam logic signed [7:0] EDGE_Y_MAX = 8'(MAZE_H - 1);

  // The player box is 3x3, so a move is checked with 9 ROM probes
  localparam logic [3:0] PROBE_CNT = 4'd9;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNDS = 2'd1,
    PROBE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Linear scan address y*96 + x, built from shifts (96 = 64 + 32)
  function automatic logic [IDX_W-1:0] pix_addr(input logic [6:0] x, input logic [5:0] y);
    pix_addr = {1'b0, y, 6'b000000} + {2'b00, y, 5'b00000} + {6'b000000, x};
  endfunction

  // Goal region: bottom edge of the box at row 61 or lower
  function automatic logic goal_row(input logic [5:0] y);
    goal_row = (({2'b00, y} + 8'd2) >= 8'd61);
  endfunction

endpackage

// File: rtl/maze_sprite_hit.sv
// Combinational test of whether a scan index falls inside the 3x3 player box.
// The box never straddles a row end, so each box row is a run of 3
// consecutive linear addresses.
module maze_sprite_hit
  import maze_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  input  logic [6:0]       box_x,
  input  logic [5:0]       box_y,
  output logic             hit
);

  logic [IDX_W-1:0] row0_s;
  logic [IDX_W-1:0] row1_s;
  logic [IDX_W-1:0] row2_s;
  logic             in0_s;
  logic             in1_s;
  logic             in2_s;

  assign row0_s = pix_addr(box_x, box_y);
  assign row1_s = row0_s + 13'd96;
  assign row2_s = row0_s + 13'd192;

  assign in0_s = (index >= row0_s) && (index <= (row0_s + 13'd2));
  assign in1_s = (index >= row1_s) && (index <= (row1_s + 13'd2));
  assign in2_s = (index >= row2_s) && (index <= (row2_s + 13'd2));

  assign hit = in0_s | in1_s | in2_s;

endmodule

// File: rtl/maze_rom_arbiter.sv
// Time-slices one maze ROM between the OLED display scan (slot 0) and a
// move checker (slot 1) that probes the 9 pixels of a candidate player box.
// Display latency is fixed: the checker only ever uses slot-1 edges.
module maze_rom_arbiter
  import maze_pkg::*;
#(
  parameter logic [15:0] WALL_COLOUR   = DEF_WALL_COLOUR,
  parameter logic [15:0] PLAYER_COLOUR = DEF_PLAYER_COLOUR,
  parameter logic [6:0]  START_X       = 7'd5,
  parameter logic [5:0]  START_Y       = 6'd5
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] pixel_index,
  output logic [15:0]      pixel_data,
  output logic [IDX_W-1:0] rom_index,
  input  logic [15:0]      rom_data,
  input  logic             move_req,
  input  logic [1:0]       move_dir,
  output logic             move_done,
  output logic             move_ok,
  output logic [6:0]       player_x,
  output logic [5:0]       player_y,
  output logic             at_goal
);

  logic              slot_r;
  state_e            state_r;
  logic [IDX_W-1:0]  pix_idx_r;
  logic signed [7:0] cand_x_r;
  logic signed [7:0] cand_y_r;
  logic [3:0]        probe_cnt_r;
  logic [1:0]        probe_row_r;
  logic [1:0]        probe_col_r;
  logic              fail_r;

  logic signed [7:0] px_s;
  logic signed [7:0] py_s;
  logic signed [7:0] cand_x_s;
  logic signed [7:0] cand_y_s;
  logic              inb_s;
  logic              probe_issue_s;
  logic [6:0]        probe_x_s;
  logic [5:0]        probe_y_s;
  logic [IDX_W-1:0]  probe_addr_s;
  logic [1:0]        probe_row_nx_s;
  logic [1:0]        probe_col_nx_s;
  logic              sprite_hit_s;

  maze_sprite_hit u_sprite_hit (
    .index (pix_idx_r),
    .box_x (player_x),
    .box_y (player_y),
    .hit   (sprite_hit_s)
  );

  // Candidate position: current position stepped one pixel, kept signed so underflow is visible
  always_comb begin
    px_s     = $signed({1'b0, player_x});
    py_s     = $signed({2'b00, player_y});
    cand_x_s = px_s;
    cand_y_s = py_s;
    case (dir_e'(move_dir))
      DIR_UP:    cand_y_s = py_s - 8'sd1;
      DIR_DOWN:  cand_y_s = py_s + 8'sd1;
      DIR_LEFT:  cand_x_s = px_s - 8'sd1;
      DIR_RIGHT: cand_x_s = px_s + 8'sd1;
      default: begin
        cand_x_s = px_s;
        cand_y_s = py_s;
      end
    endcase
  end

  // Bounds check of the latched candidate box against the 96x64 screen
  always_comb begin
    inb_s = (cand_x_r >= 8'sd0) && (cand_y_r >= 8'sd0) &&
            ((cand_x_r + 8'sd2) <= EDGE_X_MAX) &&
            ((cand_y_r + 8'sd2) <= EDGE_Y_MAX);
  end

  // Probe address generation and row-major walk through the 3x3 box
  always_comb begin
    probe_x_s    = cand_x_r[6:0] + {5'b00000, probe_col_r};
    probe_y_s    = cand_y_r[5:0] + {4'b0000, probe_row_r};
    probe_addr_s = pix_addr(probe_x_s, probe_y_s);
    if (probe_col_r == 2'd2) begin
      probe_col_nx_s = 2'd0;
      probe_row_nx_s = probe_row_r + 2'd1;
    end else begin
      probe_col_nx_s = probe_col_r + 2'd1;
      probe_row_nx_s = probe_row_r;
    end
  end

  // A probe goes out on a checker slot; the first may leave straight from BOUNDS
  always_comb begin
    probe_issue_s = 1'b0;
    if (slot_r && (probe_cnt_r < PROBE_CNT)) begin
      if (state_r == PROBE) begin
        probe_issue_s = 1'b1;
      end else if (state_r == BOUNDS) begin
        probe_issue_s = inb_s;
      end else begin
        probe_issue_s = 1'b0;
      end
    end else begin
      probe_issue_s = 1'b0;
    end
  end

  // Slot bit alternates display and checker access every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r <= 1'b0;
    end else begin
      slot_r <= ~slot_r;
    end
  end

  // ROM address mux: display address on slot 0, checker probe on slot 1
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_index <= 13'd0;
    end else if (!slot_r) begin
      rom_index <= pixel_index;
    end else if (probe_issue_s) begin
      rom_index <= probe_addr_s;
    end else begin
      rom_index <= rom_index;
    end
  end

  // Display pipeline: latch the scan index and publish the overlaid colour two cycles later
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_idx_r  <= 13'd0;
      pixel_data <= 16'h0000;
    end else if (!slot_r) begin
      pix_idx_r  <= pixel_index;
      pixel_data <= sprite_hit_s ? PLAYER_COLOUR : rom_data;
    end else begin
      pix_idx_r  <= pix_idx_r;
      pixel_data <= pixel_data;
    end
  end

  // Move checker FSM: accept, bounds test, 9 probes, then one-cycle completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cand_x_r    <= 8'sd0;
      cand_y_r    <= 8'sd0;
      probe_cnt_r <= 4'd0;
      probe_row_r <= 2'd0;
      probe_col_r <= 2'd0;
      fail_r      <= 1'b0;
      move_done   <= 1'b0;
      move_ok     <= 1'b0;
      player_x    <= START_X;
      player_y    <= START_Y;
      at_goal     <= goal_row(START_Y);
    end else begin
      move_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (move_req) begin
            cand_x_r    <= cand_x_s;
            cand_y_r    <= cand_y_s;
            probe_cnt_r <= 4'd0;
            probe_row_r <= 2'd0;
            probe_col_r <= 2'd0;
            fail_r      <= 1'b0;
            state_r     <= BOUNDS;
          end else begin
            state_r <= IDLE;
          end
        end
        BOUNDS: begin
          if (!inb_s) begin
            fail_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= PROBE;
            if (probe_issue_s) begin
              probe_cnt_r <= probe_cnt_r + 4'd1;
              probe_row_r <= probe_row_nx_s;
              probe_col_r <= probe_col_nx_s;
            end else begin
              probe_cnt_r <= probe_cnt_r;
            end
          end
        end
        PROBE: begin
          if (slot_r) begin
            // Data for the probe issued on the previous checker slot arrives now
            if ((probe_cnt_r != 4'd0) && (rom_data == WALL_COLOUR)) begin
              fail_r <= 1'b1;
            end else begin
              fail_r <= fail_r;
            end
            if (probe_cnt_r == PROBE_CNT) begin
              state_r <= DONE;
            end else begin
              probe_cnt_r <= probe_cnt_r + 4'd1;
              probe_row_r <= probe_row_nx_s;
              probe_col_r <= probe_col_nx_s;
              state_r     <= PROBE;
            end
          end else begin
            state_r <= PROBE;
          end
        end
        DONE: begin
          move_done <= 1'b1;
          move_ok   <= ~fail_r;
          if (!fail_r) begin
            player_x <= cand_x_r[6:0];
            player_y <= cand_y_r[5:0];
            at_goal  <= goal_row(cand_y_r[5:0]);
          end else begin
            player_x <= player_x;
            player_y <= player_y;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
